// File: rtl/beam_sweep_controller.sv
// Ping-pong steering-angle sweep for transmit_beamformer: frames each angle into a
// burst window followed by a listen window and drives |sin(angle)| plus sign from a 10-degree LUT.
module beam_sweep_controller #(
    parameter int unsigned PERIOD_DURATION = 32'd16777216,
    parameter int unsigned BURST_DURATION  = 32'd524288,
    parameter int unsigned MAX_STEP        = 32'd6,
    parameter int unsigned SIN_WIDTH       = 32'd17
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 enable,
    input  logic                 hold,
    output logic [SIN_WIDTH-1:0] sin_value,
    output logic                 sign_bit,
    output logic signed [3:0]    angle_idx,
    output logic                 burst_en,
    output logic                 period_start,
    output logic                 sweep_edge
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_LISTEN = 2'd2
    } state_t;

    localparam logic signed [3:0] MAX_IDX     = 4'(MAX_STEP);
    localparam logic [31:0]       BURST_LAST  = 32'(BURST_DURATION - 32'd1);
    localparam logic [31:0]       PERIOD_LAST = 32'(PERIOD_DURATION - 32'd1);

    state_t      state_r;
    logic [31:0] cnt_r;
    logic        dir_up_r;

    logic signed [3:0] step_idx_s;
    logic              step_dir_up_s;
    logic              step_edge_s;

    // Table holds Q16 sines; rescaled so 1.0 == 2^(SIN_WIDTH-1).
    function automatic logic [SIN_WIDTH-1:0] sin_lut(input logic [2:0] mag);
        logic [63:0] q16;
        case (mag)
            3'd0:    q16 = 64'd0;
            3'd1:    q16 = 64'd11380;
            3'd2:    q16 = 64'd22415;
            3'd3:    q16 = 64'd32768;
            3'd4:    q16 = 64'd42126;
            3'd5:    q16 = 64'd50203;
            3'd6:    q16 = 64'd56756;
            default: q16 = 64'd0;
        endcase
        return SIN_WIDTH'((q16 << (SIN_WIDTH - 32'd1)) >> 16);
    endfunction

    function automatic logic [2:0] abs_idx(input logic signed [3:0] idx);
        return idx[3] ? 3'(4'd0 - $unsigned(idx)) : idx[2:0];
    endfunction

    // Next angle/direction if a step is taken at this period boundary; endpoints bounce.
    always_comb begin
        step_idx_s    = angle_idx;
        step_dir_up_s = dir_up_r;
        step_edge_s   = 1'b0;
        if (hold) begin
            step_idx_s    = angle_idx;
            step_dir_up_s = dir_up_r;
        end else if (dir_up_r) begin
            if (angle_idx == MAX_IDX) begin
                step_idx_s    = MAX_IDX - 4'sd1;
                step_dir_up_s = 1'b0;
                step_edge_s   = 1'b1;
            end else begin
                step_idx_s = angle_idx + 4'sd1;
            end
        end else begin
            if (angle_idx == -MAX_IDX) begin
                step_idx_s    = -MAX_IDX + 4'sd1;
                step_dir_up_s = 1'b1;
                step_edge_s   = 1'b1;
            end else begin
                step_idx_s = angle_idx - 4'sd1;
            end
        end
    end

    // Period framing FSM; angle outputs only move on the first cycle of a new burst.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 32'd0;
            dir_up_r     <= 1'b1;
            angle_idx    <= -MAX_IDX;
            sin_value    <= sin_lut(3'(MAX_STEP));
            sign_bit     <= 1'b1;
            burst_en     <= 1'b0;
            period_start <= 1'b0;
            sweep_edge   <= 1'b0;
        end else begin
            period_start <= 1'b0;
            sweep_edge   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r      <= ST_BURST;
                        cnt_r        <= 32'd0;
                        burst_en     <= 1'b1;
                        period_start <= 1'b1;
                    end else begin
                        burst_en <= 1'b0;
                    end
                end
                ST_BURST: begin
                    cnt_r <= cnt_r + 32'd1;
                    if (cnt_r == BURST_LAST) begin
                        state_r  <= ST_LISTEN;
                        burst_en <= 1'b0;
                    end else begin
                        burst_en <= 1'b1;
                    end
                end
                ST_LISTEN: begin
                    if (cnt_r == PERIOD_LAST) begin
                        cnt_r <= 32'd0;
                        if (enable) begin
                            state_r      <= ST_BURST;
                            burst_en     <= 1'b1;
                            period_start <= 1'b1;
                            angle_idx    <= step_idx_s;
                            dir_up_r     <= step_dir_up_s;
                            sweep_edge   <= step_edge_s;
                            sin_value    <= sin_lut(abs_idx(step_idx_s));
                            sign_bit     <= step_idx_s[3];
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= 32'd0;
                    burst_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beam_sweep_controller.sv
// Directed bench for beam_sweep_controller with a short period (20), burst (5) and +/-2 sweep.
module tb_beam_sweep_controller;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              hold;
    logic [16:0]       sin_value;
    logic              sign_bit;
    logic signed [3:0] angle_idx;
    logic              burst_en;
    logic              period_start;
    logic              sweep_edge;

    int checks = 0;
    int errors = 0;

    beam_sweep_controller #(
        .PERIOD_DURATION(32'd20),
        .BURST_DURATION (32'd5),
        .MAX_STEP       (32'd2),
        .SIN_WIDTH      (32'd17)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .enable      (enable),
        .hold        (hold),
        .sin_value   (sin_value),
        .sign_bit    (sign_bit),
        .angle_idx   (angle_idx),
        .burst_en    (burst_en),
        .period_start(period_start),
        .sweep_edge  (sweep_edge)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int exp_sin(input int a);
        int m;
        m = (a < 0) ? -a : a;
        if (m == 0)      return 0;
        else if (m == 1) return 11380;
        else             return 22415;
    endfunction

    task automatic chk_angle(input string tag, input int a);
        chk({tag, "_angle"}, angle_idx, a);
        chk({tag, "_sin"}, {15'd0, sin_value}, exp_sin(a));
        chk({tag, "_sign"}, {31'd0, sign_bit}, (a < 0) ? 1 : 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_angle(tag, -2);
        chk({tag, "_burst"}, {31'd0, burst_en}, 0);
        chk({tag, "_pstart"}, {31'd0, period_start}, 0);
        chk({tag, "_edge"}, {31'd0, sweep_edge}, 0);
    endtask

    int exp_ang  [9] = '{-1, 0, 1, 2, 1, 0, -1, -2, -1};
    int exp_edge [9] = '{ 0, 0, 0, 0, 1, 0,  0,  0, 1};

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        hold   = 1'b0;
        tick(2);
        chk_reset_vals("reset");

        rst_n = 1'b1;
        tick(1);
        chk("idle_burst", {31'd0, burst_en}, 0);
        chk("idle_pstart", {31'd0, period_start}, 0);

        // first period: cycle 1 is the first burst cycle
        enable = 1'b1;
        tick(1);
        chk("p0_pstart", {31'd0, period_start}, 1);
        chk("p0_burst", {31'd0, burst_en}, 1);
        chk_angle("p0", -2);
        for (int c = 2; c <= 20; c++) begin
            tick(1);
            chk($sformatf("p0_c%0d_burst", c), {31'd0, burst_en}, (c <= 5) ? 1 : 0);
            chk($sformatf("p0_c%0d_pstart", c), {31'd0, period_start}, 0);
        end

        // free-running ping-pong sweep
        for (int p = 0; p < 9; p++) begin
            tick(1);
            chk($sformatf("sweep%0d_pstart", p + 1), {31'd0, period_start}, 1);
            chk($sformatf("sweep%0d_edge", p + 1), {31'd0, sweep_edge}, exp_edge[p]);
            chk_angle($sformatf("sweep%0d", p + 1), exp_ang[p]);
            tick(1);
            chk($sformatf("sweep%0d_edge_drop", p + 1), {31'd0, sweep_edge}, 0);
            chk($sformatf("sweep%0d_pstart_drop", p + 1), {31'd0, period_start}, 0);
            tick(18);
        end

        // hold across three boundaries: angle frozen at -1 (dir up)
        hold = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick(1);
            chk($sformatf("hold%0d_pstart", p), {31'd0, period_start}, 1);
            chk($sformatf("hold%0d_edge", p), {31'd0, sweep_edge}, 0);
            chk_angle($sformatf("hold%0d", p), -1);
            tick(19);
        end
        hold = 1'b0;
        tick(1);
        chk("unhold_pstart", {31'd0, period_start}, 1);
        chk_angle("unhold", 0);

        // enable drops during the burst: both windows still complete
        tick(1);
        enable = 1'b0;
        for (int c = 3; c <= 20; c++) begin
            tick(1);
            chk($sformatf("drop_c%0d_burst", c), {31'd0, burst_en}, (c <= 5) ? 1 : 0);
        end
        for (int c = 0; c < 4; c++) begin
            tick(1);
            chk($sformatf("off%0d_burst", c), {31'd0, burst_en}, 0);
            chk($sformatf("off%0d_pstart", c), {31'd0, period_start}, 0);
        end
        chk_angle("off", 0);

        // re-enable resumes from stored angle without stepping
        enable = 1'b1;
        tick(1);
        chk("resume_pstart", {31'd0, period_start}, 1);
        chk("resume_burst", {31'd0, burst_en}, 1);
        chk_angle("resume", 0);
        tick(20);
        chk("resume_next_pstart", {31'd0, period_start}, 1);
        chk_angle("resume_next", 1);

        // async reset in the middle of a burst
        tick(1);
        chk("preirst_burst", {31'd0, burst_en}, 1);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk_reset_vals("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
